// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports and a hardwired zero register.
// A same-edge write forwards its data to a read of the same (non-zero) index.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              clr_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              valid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              valid_b
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              valid_a_q, valid_a_d;
  logic              valid_b_q, valid_b_d;
  logic              wr_en;
  logic              byp_a, byp_b;

  assign wr_en = we && (waddr != '0);
  assign byp_a = wr_en && (waddr == raddr_a);
  assign byp_b = wr_en && (waddr == raddr_b);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr] = wdata;
    end
    // Entry 0 never holds anything but zero, so reads of it need no special case.
    mem_d[0] = '0;
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    valid_a_d = re_a;
    if (re_a) begin
      rdata_a_d = byp_a ? wdata : mem_q[raddr_a];
    end
  end

  always_comb begin
    rdata_b_d = rdata_b_q;
    valid_b_d = re_b;
    if (re_b) begin
      rdata_b_d = byp_b ? wdata : mem_q[raddr_b];
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      mem_q     <= '{default: '0};
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign valid_a = valid_a_q;
  assign rdata_b = rdata_b_q;
  assign valid_b = valid_b_q;

endmodule
